// File: rtl/lexer_pkg.sv
// Shared definitions for the Hlang byte-stream lexer.
//   - token kind codes carried in the upper byte of every token
//   - ASCII codes the lexer reacts to
//   - FSM state type and token width helper
package lexer_pkg;

   localparam logic [7:0] K_SEMICOLON = 8'h00;
   localparam logic [7:0] K_OUT       = 8'h01;
   localparam logic [7:0] K_VAR       = 8'h02;
   localparam logic [7:0] K_EQUAL     = 8'h03;
   localparam logic [7:0] K_IF        = 8'h04;
   localparam logic [7:0] K_BRACKET_A = 8'h05;
   localparam logic [7:0] K_BRACKET_B = 8'h06;
   localparam logic [7:0] K_SHIFT_L   = 8'h07;
   localparam logic [7:0] K_SHIFT_R   = 8'h08;
   localparam logic [7:0] K_PLUS      = 8'h09;
   localparam logic [7:0] K_MINUS     = 8'h0A;
   localparam logic [7:0] K_NUM       = 8'h0B;
   localparam logic [7:0] K_EOF       = 8'h0C;
   // UNKNOWN tokens are all-ones in both KIND and VALUE
   localparam logic [7:0] K_UNKNOWN   = 8'hFF;

   localparam logic [7:0] C_NUL   = 8'h00;
   localparam logic [7:0] C_FF    = 8'hFF;
   localparam logic [7:0] C_TAB   = 8'h09;
   localparam logic [7:0] C_LF    = 8'h0A;
   localparam logic [7:0] C_CR    = 8'h0D;
   localparam logic [7:0] C_SP    = 8'h20;
   localparam logic [7:0] C_LPAR  = 8'h28;
   localparam logic [7:0] C_RPAR  = 8'h29;
   localparam logic [7:0] C_PLUS  = 8'h2B;
   localparam logic [7:0] C_MINUS = 8'h2D;
   localparam logic [7:0] C_DIG0  = 8'h30;
   localparam logic [7:0] C_DIG9  = 8'h39;
   localparam logic [7:0] C_SEMI  = 8'h3B;
   localparam logic [7:0] C_LT    = 8'h3C;
   localparam logic [7:0] C_EQ    = 8'h3D;
   localparam logic [7:0] C_GT    = 8'h3E;
   localparam logic [7:0] C_UE    = 8'h45;
   localparam logic [7:0] C_UF    = 8'h46;
   localparam logic [7:0] C_UO    = 8'h4F;
   localparam logic [7:0] C_LA    = 8'h61;
   localparam logic [7:0] C_LF_CH = 8'h66;
   localparam logic [7:0] C_LI    = 8'h69;
   localparam logic [7:0] C_LO    = 8'h6F;
   localparam logic [7:0] C_LT_CH = 8'h74;
   localparam logic [7:0] C_LU    = 8'h75;
   localparam logic [7:0] C_LZ    = 8'h7A;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } lex_state_t;

   function automatic int tok_w(input int val_w);
      return 8 + val_w;
   endfunction

endpackage

// File: rtl/token_fifo.sv
// Synchronous token FIFO with up to two writes and one read per cycle.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   PUSH_A / DATA_A    first token written this cycle
//   PUSH_B / DATA_B    second token, lands behind DATA_A when both push
//   POP                remove head (ignored while empty)
//   FREE               number of empty entries
//   EMPTY              no entries held
//   HEAD               oldest entry; last popped value while empty
module token_fifo
   import lexer_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 4
)
(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     PUSH_A,
   input  logic [W-1:0]             DATA_A,
   input  logic                     PUSH_B,
   input  logic [W-1:0]             DATA_B,
   input  logic                     POP,
   output logic [$clog2(DEPTH):0]   FREE,
   output logic                     EMPTY,
   output logic [W-1:0]             HEAD
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [W-1:0]  last_q;
   logic          pop_ok;

   assign pop_ok = POP && (count != '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (PUSH_A) mem[wr_ptr] <= DATA_A;
         if (PUSH_B) mem[wr_ptr + PW'(PUSH_A)] <= DATA_B;
         wr_ptr <= wr_ptr + PW'(PUSH_A) + PW'(PUSH_B);
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
            last_q <= mem[rd_ptr];
         end
         count <= count + CW'(PUSH_A) + CW'(PUSH_B) - CW'(pop_ok);
      end
   end

   // the popped token stays visible after the FIFO runs dry
   assign EMPTY = (count == '0);
   assign HEAD  = EMPTY ? last_q : mem[rd_ptr];
   assign FREE  = CW'(DEPTH) - count;

endmodule

// File: rtl/lexer_stream.sv
// Byte-stream lexer for Hlang source: bytes in, {KIND, VALUE} tokens out.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   I_VALID/I_READY     source byte handshake, I_DATA = ASCII byte
//   O_VALID/O_READY     token handshake, O_DATA = {KIND[7:0], VALUE}
//   FOUND_EOF           sticky, set once the EOF token has been handed out
//
// state   | meaning
// RUN     | accepting bytes while the FIFO has room for two tokens
// DONE    | EOF seen; input closed, FIFO drains; left only by RST
module lexer_stream
   import lexer_pkg::*;
#(
   parameter int VAL_W      = 8,
   parameter int MAX_LEN    = 8,
   parameter int FIFO_DEPTH = 4
)
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               I_VALID,
   output logic               I_READY,
   input  logic [7:0]         I_DATA,
   output logic               O_VALID,
   input  logic               O_READY,
   output logic [8+VAL_W-1:0] O_DATA,
   output logic               FOUND_EOF
);

   localparam int TW = tok_w(VAL_W);
   localparam int LW = $clog2(MAX_LEN + 2);
   localparam int AW = VAL_W + 4;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [AW-1:0] NUM_MAX = AW'((2 ** VAL_W) - 1);

   lex_state_t    state, state_nxt;
   logic [7:0]    wbuf [MAX_LEN];
   logic [LW-1:0] len;
   logic          all_dig;
   logic          num_ovf;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_nxt;

   logic          accept;
   logic          is_skip, is_space, is_punct, is_eofb, is_digit;
   logic          flush_byte, too_long, word_nonempty, eof_now;
   logic [7:0]    punct_kind;
   logic [TW-1:0] word_tok, tail_tok;
   logic          word_is_eof, word_push, tail_push;
   logic [CW-1:0] fifo_free;
   logic          fifo_empty;
   logic [TW-1:0] fifo_head;

   always_comb begin
      is_skip    = 1'b0;
      is_space   = 1'b0;
      is_punct   = 1'b0;
      is_eofb    = 1'b0;
      punct_kind = K_SEMICOLON;
      case (I_DATA)
         C_CR, C_TAB: is_skip  = 1'b1;
         C_SP, C_LF:  is_space = 1'b1;
         C_NUL, C_FF: is_eofb  = 1'b1;
         C_SEMI:  begin is_punct = 1'b1; punct_kind = K_SEMICOLON; end
         C_EQ:    begin is_punct = 1'b1; punct_kind = K_EQUAL;     end
         C_LPAR:  begin is_punct = 1'b1; punct_kind = K_BRACKET_A; end
         C_RPAR:  begin is_punct = 1'b1; punct_kind = K_BRACKET_B; end
         C_PLUS:  begin is_punct = 1'b1; punct_kind = K_PLUS;      end
         C_MINUS: begin is_punct = 1'b1; punct_kind = K_MINUS;     end
         default: ;
      endcase
   end

   assign is_digit      = (I_DATA >= C_DIG0) && (I_DATA <= C_DIG9);
   assign acc_nxt       = AW'(acc * AW'(10)) + AW'(I_DATA - C_DIG0);
   assign flush_byte    = is_space || is_punct || is_eofb;
   assign too_long      = len > LW'(MAX_LEN);
   assign word_nonempty = len != '0;

   // keyword buffers only need the first three characters; longer words
   // never match a keyword, so too-long words fall through to UNKNOWN
   always_comb begin
      word_tok    = {K_UNKNOWN, {VAL_W{1'b1}}};
      word_is_eof = 1'b0;
      if (!too_long) begin
         if (len == LW'(3) && wbuf[0] == C_LO && wbuf[1] == C_LU && wbuf[2] == C_LT_CH)
            word_tok = {K_OUT, {VAL_W{1'b0}}};
         else if (len == LW'(2) && wbuf[0] == C_LI && wbuf[1] == C_LF_CH)
            word_tok = {K_IF, {VAL_W{1'b0}}};
         else if (len == LW'(2) && wbuf[0] == C_LT && wbuf[1] == C_LT)
            word_tok = {K_SHIFT_L, {VAL_W{1'b0}}};
         else if (len == LW'(2) && wbuf[0] == C_GT && wbuf[1] == C_GT)
            word_tok = {K_SHIFT_R, {VAL_W{1'b0}}};
         else if (len == LW'(3) && wbuf[0] == C_UE && wbuf[1] == C_UO && wbuf[2] == C_UF) begin
            word_tok    = {K_EOF, {VAL_W{1'b0}}};
            word_is_eof = 1'b1;
         end else if (len == LW'(1) && wbuf[0] >= C_LA && wbuf[0] <= C_LZ)
            word_tok = {K_VAR, VAL_W'(wbuf[0])};
         else if (all_dig && !num_ovf)
            word_tok = {K_NUM, acc[VAL_W-1:0]};
      end
   end

   assign eof_now   = is_eofb || (flush_byte && word_nonempty && word_is_eof);
   assign accept    = I_VALID && I_READY;
   assign word_push = accept && flush_byte && word_nonempty;
   assign tail_push = accept && (is_punct || is_eofb);
   assign tail_tok  = is_eofb ? {K_EOF, {VAL_W{1'b0}}}
                              : {punct_kind, VAL_W'(punct_kind == K_SEMICOLON)};

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      I_READY   = 1'b0;
      case (state)
         ST_RUN: begin
            I_READY = !RST && (fifo_free >= CW'(2));
            if (I_VALID && I_READY && eof_now) state_nxt = ST_DONE;
         end
         ST_DONE: ;
         default: state_nxt = ST_RUN;
      endcase
   end

   // number accumulator tracks the word incrementally; overflow is sticky
   // so a later wrap of the accumulator cannot hide it
   always_ff @(posedge CLK) begin
      if (RST) begin
         len     <= '0;
         all_dig <= 1'b1;
         num_ovf <= 1'b0;
         acc     <= '0;
         for (int i = 0; i < MAX_LEN; i++) wbuf[i] <= 8'h00;
      end else if (accept) begin
         if (flush_byte) begin
            len     <= '0;
            all_dig <= 1'b1;
            num_ovf <= 1'b0;
            acc     <= '0;
         end else if (!is_skip) begin
            for (int i = 0; i < MAX_LEN; i++)
               if (len == LW'(i)) wbuf[i] <= I_DATA;
            if (!too_long) len <= len + LW'(1);
            all_dig <= all_dig && is_digit;
            if (is_digit) begin
               acc <= acc_nxt;
               if (acc_nxt > NUM_MAX) num_ovf <= 1'b1;
            end
         end
      end
   end

   token_fifo #(.W(TW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK    (CLK),
      .RST    (RST),
      .PUSH_A (word_push),
      .DATA_A (word_tok),
      .PUSH_B (tail_push),
      .DATA_B (tail_tok),
      .POP    (O_VALID && O_READY),
      .FREE   (fifo_free),
      .EMPTY  (fifo_empty),
      .HEAD   (fifo_head)
   );

   assign O_VALID = !fifo_empty;
   assign O_DATA  = fifo_head;

   always_ff @(posedge CLK) begin
      if (RST)
         FOUND_EOF <= 1'b0;
      else if (O_VALID && O_READY && fifo_head[TW-1 -: 8] == K_EOF)
         FOUND_EOF <= 1'b1;
   end

endmodule

// File: tb/tb_lexer_stream.sv
module tb_lexer_stream;
   import lexer_pkg::*;

   localparam int VAL_W   = 8;
   localparam int MAX_LEN = 8;
   localparam int DEPTH   = 4;
   localparam int TW      = 8 + VAL_W;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          I_VALID = 1'b0;
   logic          I_READY;
   logic [7:0]    I_DATA = 8'h00;
   logic          O_VALID;
   logic          O_READY = 1'b1;
   logic [TW-1:0] O_DATA;
   logic          FOUND_EOF;

   int checks = 0;
   int errors = 0;

   logic [TW-1:0] exp_q[$];
   logic [7:0]    word_q[$];
   bit            exp_found = 1'b0;
   bit            rand_rdy  = 1'b0;
   bit            prev_hold = 1'b0;
   logic [TW-1:0] prev_data = '0;

   localparam logic [7:0] PK [6] = '{K_SEMICOLON, K_EQUAL, K_BRACKET_A,
                                     K_BRACKET_B, K_PLUS, K_MINUS};
   string punct_chars = ";=()+-";

   always #5 CLK = ~CLK;

   lexer_stream #(.VAL_W(VAL_W), .MAX_LEN(MAX_LEN), .FIFO_DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .I_VALID   (I_VALID),
      .I_READY   (I_READY),
      .I_DATA    (I_DATA),
      .O_VALID   (O_VALID),
      .O_READY   (O_READY),
      .O_DATA    (O_DATA),
      .FOUND_EOF (FOUND_EOF)
   );

   task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_word(input string k);
      if (word_q.size() != k.len()) return 1'b0;
      for (int i = 0; i < k.len(); i++)
         if (word_q[i] != k[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic push_tok(input logic [7:0] kind, input logic [VAL_W-1:0] val);
      exp_q.push_back({kind, val});
   endtask

   task automatic flush_word();
      longint v;
      bit     dig;
      if (word_q.size() == 0) return;
      if (is_word("out"))      push_tok(K_OUT, '0);
      else if (is_word("if"))  push_tok(K_IF, '0);
      else if (is_word("<<"))  push_tok(K_SHIFT_L, '0);
      else if (is_word(">>"))  push_tok(K_SHIFT_R, '0);
      else if (is_word("EOF")) push_tok(K_EOF, '0);
      else if (word_q.size() == 1 && word_q[0] >= 8'h61 && word_q[0] <= 8'h7A)
         push_tok(K_VAR, word_q[0]);
      else begin
         dig = (word_q.size() <= MAX_LEN);
         v = 0;
         if (dig)
            foreach (word_q[i]) begin
               if (word_q[i] < 8'h30 || word_q[i] > 8'h39) dig = 1'b0;
               else v = v * 10 + longint'(word_q[i] - 8'h30);
            end
         if (dig && v <= (longint'(1) << VAL_W) - 1) push_tok(K_NUM, VAL_W'(v));
         else push_tok(8'hFF, {VAL_W{1'b1}});
      end
      word_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      int pidx;
      pidx = -1;
      for (int i = 0; i < punct_chars.len(); i++)
         if (b == punct_chars[i]) pidx = i;
      if (b == 8'h0D || b == 8'h09) begin
      end else if (b == 8'h20 || b == 8'h0A) begin
         flush_word();
      end else if (pidx >= 0) begin
         flush_word();
         push_tok(PK[pidx], (pidx == 0) ? VAL_W'(1) : VAL_W'(0));
      end else if (b == 8'h00 || b == 8'hFF) begin
         flush_word();
         push_tok(K_EOF, '0);
      end else begin
         word_q.push_back(b);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge CLK) begin
      logic [TW-1:0] e;
      if (RST) begin
         prev_hold = 1'b0;
      end else begin
         chk("found_eof", TW'(FOUND_EOF), TW'(exp_found));
         if (prev_hold) begin
            chk("hold_valid", TW'(O_VALID), TW'(1));
            chk("hold_data", O_DATA, prev_data);
         end
         if (O_VALID && O_READY) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_token: got %h expected none", O_DATA);
            end else begin
               e = exp_q.pop_front();
               chk("token", O_DATA, e);
               if (e[TW-1 -: 8] == K_EOF) exp_found = 1'b1;
            end
         end
         prev_hold = O_VALID && !O_READY;
         prev_data = O_DATA;
      end
   end

   always @(posedge CLK) begin
      if (rand_rdy) begin
         #1;
         O_READY = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- stimulus helpers (called just after a rising edge) ----------------
   task automatic do_reset(input int cyc);
      RST = 1'b1;
      I_VALID = 1'b0;
      repeat (cyc) begin
         @(negedge CLK);
         chk("i_ready_in_reset", TW'(I_READY), TW'(0));
         @(posedge CLK);
         #1;
      end
      RST = 1'b0;
      exp_found = 1'b0;
      word_q.delete();
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      I_VALID = 1'b1;
      I_DATA  = b;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge CLK);
         ok = I_READY;
         @(posedge CLK);
         #1;
      end
      I_VALID = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: byte %h not accepted, expected acceptance", b);
      end else begin
         model_byte(b);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || O_VALID) && n < 1000) begin
         @(posedge CLK);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || O_VALID) begin
         errors++;
         $display("FAIL drain_timeout: %0d tokens left, expected 0", exp_q.size());
      end
      @(negedge CLK);
      @(posedge CLK);
      #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      string pool;
      string kws [4];
      pool = "abcz0159 ;=()+-\n\r\t<>outif";
      kws  = '{"out ", "if(", "<< ", ">>;"};

      do_reset(3);
      @(negedge CLK);
      chk("rst_i_ready", TW'(I_READY), TW'(1));
      chk("rst_o_valid", TW'(O_VALID), TW'(0));
      chk("rst_o_data", O_DATA, TW'(0));
      chk("rst_found_eof", TW'(FOUND_EOF), TW'(0));
      @(posedge CLK);
      #1;

      // simple assignment
      send_str("a = 12;\n");
      send_byte(8'h00);
      drain();
      chk("t1_found_eof", TW'(FOUND_EOF), TW'(1));
      chk("t1_done_ready", TW'(I_READY), TW'(0));
      do_reset(1);

      // punctuation self-delimits
      send_str("out(b+3)<<1;");
      send_byte(8'h00);
      drain();
      do_reset(1);

      // number range and too-long word
      send_str("255 256 123456789 ");
      send_byte(8'h00);
      drain();
      do_reset(1);

      // backpressure: FIFO fills, input stalls, nothing lost
      O_READY = 1'b0;
      fork
         send_str("a;b;c;");
         begin
            repeat (20) @(posedge CLK);
            #1;
            chk("bp_i_ready_low", TW'(I_READY), TW'(0));
            chk("bp_o_valid", TW'(O_VALID), TW'(1));
            O_READY = 1'b1;
         end
      join
      send_byte(8'h00);
      drain();
      do_reset(1);

      // reset mid-word discards the partial word
      send_str("ab");
      do_reset(1);
      send_str("x;");
      send_byte(8'h00);
      drain();
      do_reset(1);

      // skipped whitespace, 0xFF as EOF, input closed afterwards
      send_str("if \r\t\n\n  if");
      send_byte(8'hFF);
      drain();
      I_VALID = 1'b1;
      I_DATA  = 8'h61;
      repeat (6) begin
         @(negedge CLK);
         chk("done_i_ready", TW'(I_READY), TW'(0));
         @(posedge CLK);
         #1;
      end
      I_VALID = 1'b0;
      do_reset(2);

      // randomized streams with random consumer stalls
      rand_rdy = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
               send_str(kws[int'($urandom_range(0, 3))]);
            else
               send_byte(pool[int'($urandom_range(0, pool.len() - 1))]);
         end
         send_byte(8'h00);
         drain();
         do_reset(2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
